// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the CPU data port and the data memory.
// master = CPU side (drives requests), slave = memory side (returns load data).
// Ports: mem_w/mem_r/addr/wr_data/dm_type request, rd_data/rd_valid response.
interface dmem_responder_if;
    logic        mem_w;
    logic        mem_r;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  dm_type;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output mem_w, mem_r, addr, wr_data, dm_type,
        input  rd_data, rd_valid
    );

    modport slave (
        input  mem_w, mem_r, addr, wr_data, dm_type,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory target: byte/half/word stores with lane merge, extended loads, misalignment trap.
// Latency: store lands at the sampling edge; load data and rd_valid appear one cycle after the request.
// Backpressure: none, one request accepted per cycle; mem_w+mem_r together is a store only.
// Ports: clk, reset (sync, active-high), bus (dmem_responder_if.slave), err_clr/err/err_addr sticky
// misalignment record. Optional macro DMEM_STATS_EN adds ld_cnt/st_cnt saturating counters.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter bit          RESP_ON_ERR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_responder_if.slave        bus,
    input  logic                   err_clr,
    output logic                   err,
    output logic [31:0]            err_addr
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]            ld_cnt,
    output logic [31:0]            st_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } acc_size_e;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;

    acc_size_e   acc_size;
    logic        acc_signed;
    logic        misaligned;
    logic        st_fire;
    logic        ld_fire;
    logic        ld_err_fire;
    logic        err_fire;
    logic [3:0]  wr_be;
    logic [31:0] wr_lane;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    // Upper address bits only alias the array; they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:DEPTH_LOG2+2];

    assign word_idx = bus.addr[DEPTH_LOG2+1:2];

    // Access type decode; codes 101-111 fall through to word.
    always_comb begin
        acc_size   = SZ_WORD;
        acc_signed = 1'b0;
        unique case (bus.dm_type)
            3'b001:  begin acc_size = SZ_HALF; acc_signed = 1'b1; end
            3'b010:  begin acc_size = SZ_HALF; acc_signed = 1'b0; end
            3'b011:  begin acc_size = SZ_BYTE; acc_signed = 1'b1; end
            3'b100:  begin acc_size = SZ_BYTE; acc_signed = 1'b0; end
            default: begin acc_size = SZ_WORD; acc_signed = 1'b0; end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (acc_size)
            SZ_WORD: misaligned = (bus.addr[1:0] != 2'b00);
            SZ_HALF: misaligned = bus.addr[0];
            default: misaligned = 1'b0;
        endcase
    end

    // A simultaneous store+load is a store: the load side is masked by mem_w.
    assign st_fire     = !reset && bus.mem_w && !misaligned;
    assign ld_fire     = !reset && bus.mem_r && !bus.mem_w && !misaligned;
    assign ld_err_fire = !reset && bus.mem_r && !bus.mem_w && misaligned;
    assign err_fire    = !reset && (bus.mem_w || bus.mem_r) && misaligned;

    // Store lane replication so every byte position sees the active lane; wr_be picks.
    always_comb begin
        wr_be   = 4'b1111;
        wr_lane = bus.wr_data;
        case (acc_size)
            SZ_HALF: begin
                wr_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{bus.wr_data[15:0]}};
            end
            SZ_BYTE: begin
                wr_be   = 4'b0001 << bus.addr[1:0];
                wr_lane = {4{bus.wr_data[7:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_lane = bus.wr_data;
            end
        endcase
    end

    // Array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {bus.addr[1:0], 3'b000};

    always_comb begin
        rd_ext = rd_word;
        case (acc_size)
            SZ_HALF: rd_ext = {{16{acc_signed & rd_shift[15]}}, rd_shift[15:0]};
            SZ_BYTE: rd_ext = {{24{acc_signed & rd_shift[7]}}, rd_shift[7:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            if (ld_fire) begin
                bus.rd_data  <= rd_ext;
                bus.rd_valid <= 1'b1;
            end else if (ld_err_fire && RESP_ON_ERR) begin
                bus.rd_data  <= '0;
                bus.rd_valid <= 1'b1;
            end
        end
    end

    // Sticky error: only the first offending address is kept, but a clear
    // arriving with a new fault re-arms capture so the new address wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (err_fire) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_addr <= bus.addr;
            end
        end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= '0;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (ld_fire && ld_cnt != 32'hFFFF_FFFF) begin
                ld_cnt <= ld_cnt + 32'd1;
            end
            if (st_fire && st_cnt != 32'hFFFF_FFFF) begin
                st_cnt <= st_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
